// File: rtl/divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst_n (async, active-low), start, A (dividend), B (divisor),
//        quotient, remainder, done (1-cycle pulse), busy, divzero.
// Optional feature macro: DIVIDER_DIVZERO_EN (1-cycle divide-by-zero path).
module divider #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             divzero
);

    localparam int CW = $clog2(width + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        ZERO
    } state_t;

    state_t          state;
    logic [width:0]   r;
    logic [width-1:0] q;
    logic [width-1:0] d;
    logic [CW-1:0]    count;

    logic [width:0]   t;
    logic [width:0]   r_next;
    logic [width-1:0] q_next;
    logic             ge;

    // The partial remainder never exceeds the divisor after a step, so its
    // top bit is only headroom for the trial subtraction.
    logic unused_msb;
    assign unused_msb = r[width];

    always_comb begin
        t      = {r[width-1:0], q[width-1]};
        ge     = (t >= {1'b0, d});
        r_next = ge ? (t - {1'b0, d}) : t;
        q_next = {q[width-2:0], ge};
    end

`ifndef DIVIDER_DIVZERO_EN
    assign divzero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            r         <= '0;
            q         <= '0;
            d         <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
`ifdef DIVIDER_DIVZERO_EN
            divzero   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        r     <= '0;
                        q     <= A;
                        d     <= B;
                        count <= CW'(width);
                        busy  <= 1'b1;
`ifdef DIVIDER_DIVZERO_EN
                        state <= (B == '0) ? ZERO : RUN;
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    r     <= r_next;
                    q     <= q_next;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        quotient  <= q_next;
                        remainder <= r_next[width-1:0];
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
`ifdef DIVIDER_DIVZERO_EN
                // Q still holds the captured dividend here.
                ZERO: begin
                    quotient  <= '1;
                    remainder <= q;
                    done      <= 1'b1;
                    divzero   <= 1'b1;
                    state     <= DONE;
                end
`endif
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
`ifdef DIVIDER_DIVZERO_EN
                    divzero <= 1'b0;
`endif
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
